// File: rtl/intersection_controller.sv
// Two-way intersection sequencer: NS/EW signal heads with all-red clearance
// between directions and an exclusive pedestrian walk phase served from a
// latched request.
//
// Handshake: ped_req is a level-or-pulse request sampled on every enabled
// cycle. When a new request is latched, ped_ack pulses for exactly one cycle.
// The latched request is consumed on the edge that enters WALK.
module intersection_controller #(
  parameter int GREEN_CYCLES  = 20,
  parameter int YELLOW_CYCLES = 7,
  parameter int ALLRED_CYCLES = 3,
  parameter int WALK_CYCLES   = 10,
  parameter int CNT_W         = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic ped_req,
  output logic ped_ack,
  output logic ped_walk,
  output logic ns_red,
  output logic ns_yellow,
  output logic ns_green,
  output logic ew_red,
  output logic ew_yellow,
  output logic ew_green
);

  typedef enum logic [2:0] {
    CLR_TO_NS,
    NS_GREEN,
    NS_YELLOW,
    CLR_TO_EW,
    EW_GREEN,
    EW_YELLOW,
    WALK
  } state_t;

  // Counter load values: each state lasts DURATION enabled cycles.
  localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_CYCLES - 1);
  localparam logic [CNT_W-1:0] WALK_LD   = CNT_W'(WALK_CYCLES - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             next_dir, next_dir_n;   // 0 = NS green after WALK, 1 = EW
  logic             ped_pending, ped_pending_n;
  logic             ack_q, ack_n;
  logic             latch;

  function automatic logic [CNT_W-1:0] load_val(input state_t s);
    case (s)
      NS_GREEN, EW_GREEN:   load_val = GREEN_LD;
      NS_YELLOW, EW_YELLOW: load_val = YELLOW_LD;
      WALK:                 load_val = WALK_LD;
      default:              load_val = ALLRED_LD;
    endcase
  endfunction

  // State, counter, direction memory and pedestrian latch registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= CLR_TO_NS;
      cnt         <= ALLRED_LD;
      next_dir    <= 1'b0;
      ped_pending <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      next_dir    <= next_dir_n;
      ped_pending <= ped_pending_n;
      ack_q       <= ack_n;
    end
  end

  // Next-state, counter and request-latch logic; everything holds when disabled.
  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    next_dir_n    = next_dir;
    ped_pending_n = ped_pending;
    ack_n         = 1'b0;
    // Entering WALK implies ped_pending=1, so a request on that edge is
    // absorbed automatically; requests during WALK are ignored.
    latch         = enable && ped_req && !ped_pending && (state != WALK);
    if (enable) begin
      if (latch) begin
        ped_pending_n = 1'b1;
        ack_n         = 1'b1;
      end
      if (cnt == '0) begin
        case (state)
          CLR_TO_NS: begin
            if (ped_pending) begin
              state_n       = WALK;
              next_dir_n    = 1'b0;
              ped_pending_n = 1'b0;
            end else begin
              state_n = NS_GREEN;
            end
          end
          NS_GREEN:  state_n = NS_YELLOW;
          NS_YELLOW: state_n = CLR_TO_EW;
          CLR_TO_EW: begin
            if (ped_pending) begin
              state_n       = WALK;
              next_dir_n    = 1'b1;
              ped_pending_n = 1'b0;
            end else begin
              state_n = EW_GREEN;
            end
          end
          EW_GREEN:  state_n = EW_YELLOW;
          EW_YELLOW: state_n = CLR_TO_NS;
          WALK:      state_n = next_dir ? EW_GREEN : NS_GREEN;
          default:   state_n = CLR_TO_NS;
        endcase
        cnt_n = load_val(state_n);
      end else begin
        cnt_n = cnt - 1'b1;
      end
    end
  end

  // Moore lamp decode: exactly one lamp per head, never both heads non-red.
  always_comb begin
    ns_red    = 1'b1;
    ns_yellow = 1'b0;
    ns_green  = 1'b0;
    ew_red    = 1'b1;
    ew_yellow = 1'b0;
    ew_green  = 1'b0;
    ped_walk  = 1'b0;
    case (state)
      NS_GREEN:  begin ns_red = 1'b0; ns_green  = 1'b1; end
      NS_YELLOW: begin ns_red = 1'b0; ns_yellow = 1'b1; end
      EW_GREEN:  begin ew_red = 1'b0; ew_green  = 1'b1; end
      EW_YELLOW: begin ew_red = 1'b0; ew_yellow = 1'b1; end
      WALK:      ped_walk = 1'b1;
      default:   ;
    endcase
  end

  assign ped_ack = ack_q;

endmodule

// File: tb/tb_intersection_controller.sv
// Bench for intersection_controller: a default-parameter instance and an
// all-ones-duration instance share stimulus and are compared every cycle
// against a phase/elapsed-time reference model.
module tb_intersection_controller;

  logic clk, reset, enable, ped_req;
  logic a_ack, a_walk, a_nsr, a_nsy, a_nsg, a_ewr, a_ewy, a_ewg;
  logic b_ack, b_walk, b_nsr, b_nsy, b_nsg, b_ewr, b_ewy, b_ewg;
  logic [7:0] obs_a, obs_b;

  int n_checks = 0;
  int n_fail   = 0;

  // Model phases, numbered in NS->EW cycle order; 6 is the walk phase.
  localparam int PH_CLR_NS = 0, PH_NS_G = 1, PH_NS_Y = 2;
  localparam int PH_CLR_EW = 3, PH_EW_G = 4, PH_EW_Y = 5, PH_WALK = 6;

  int m_phase[2];
  int m_elapsed[2];
  bit m_pend[2];
  bit m_ack[2];
  bit m_next_ns[2];

  intersection_controller dut_a (
    .clk(clk), .reset(reset), .enable(enable), .ped_req(ped_req),
    .ped_ack(a_ack), .ped_walk(a_walk),
    .ns_red(a_nsr), .ns_yellow(a_nsy), .ns_green(a_nsg),
    .ew_red(a_ewr), .ew_yellow(a_ewy), .ew_green(a_ewg)
  );

  intersection_controller #(
    .GREEN_CYCLES(1), .YELLOW_CYCLES(1), .ALLRED_CYCLES(1), .WALK_CYCLES(1)
  ) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .ped_req(ped_req),
    .ped_ack(b_ack), .ped_walk(b_walk),
    .ns_red(b_nsr), .ns_yellow(b_nsy), .ns_green(b_nsg),
    .ew_red(b_ewr), .ew_yellow(b_ewy), .ew_green(b_ewg)
  );

  assign obs_a = {a_ack, a_walk, a_nsr, a_nsy, a_nsg, a_ewr, a_ewy, a_ewg};
  assign obs_b = {b_ack, b_walk, b_nsr, b_nsy, b_nsg, b_ewr, b_ewy, b_ewg};

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int dur(input int k, input int p);
    if (k == 1) return 1;
    case (p)
      PH_NS_G, PH_EW_G: return 20;
      PH_NS_Y, PH_EW_Y: return 7;
      PH_WALK:          return 10;
      default:          return 3;
    endcase
  endfunction

  // Expected {ack, walk, ns r/y/g, ew r/y/g} from a model phase.
  function automatic logic [7:0] exp_out(input int p, input bit ack);
    logic [2:0] ns, ew;
    ns = (p == PH_NS_G) ? 3'b001 : (p == PH_NS_Y) ? 3'b010 : 3'b100;
    ew = (p == PH_EW_G) ? 3'b001 : (p == PH_EW_Y) ? 3'b010 : 3'b100;
    return {ack, (p == PH_WALK), ns, ew};
  endfunction

  task automatic model_step(input int k, input bit rst, input bit en, input bit rq);
    bit lat;
    if (rst) begin
      m_phase[k] = PH_CLR_NS; m_elapsed[k] = 0;
      m_pend[k] = 0; m_ack[k] = 0; m_next_ns[k] = 1;
    end else if (!en) begin
      m_ack[k] = 0;
    end else begin
      lat = rq && !m_pend[k] && (m_phase[k] != PH_WALK);
      m_ack[k] = lat;
      if (m_elapsed[k] + 1 >= dur(k, m_phase[k])) begin
        m_elapsed[k] = 0;
        if ((m_phase[k] == PH_CLR_NS || m_phase[k] == PH_CLR_EW) && m_pend[k]) begin
          m_next_ns[k] = (m_phase[k] == PH_CLR_NS);
          m_phase[k] = PH_WALK;
          m_pend[k] = 0;
        end else if (m_phase[k] == PH_WALK) begin
          m_phase[k] = m_next_ns[k] ? PH_NS_G : PH_EW_G;
        end else begin
          m_phase[k] = (m_phase[k] + 1) % 6;
        end
      end else begin
        m_elapsed[k]++;
      end
      if (lat) m_pend[k] = 1;
    end
  endtask

  task automatic compare_all();
    check("out_a", obs_a, exp_out(m_phase[0], m_ack[0]));
    check("out_b", obs_b, exp_out(m_phase[1], m_ack[1]));
    check("safe_a", a_nsr | a_ewr, 1);
    check("safe_b", b_nsr | b_ewr, 1);
    check("ns1hot_a", $countones({a_nsr, a_nsy, a_nsg}), 1);
    check("ew1hot_a", $countones({a_ewr, a_ewy, a_ewg}), 1);
  endtask

  // One clock: drive inputs, advance the model on the edge, sample #1 later.
  task automatic cycle(input bit rst, input bit en, input bit rq);
    reset = rst; enable = en; ped_req = rq;
    @(posedge clk);
    model_step(0, rst, en, rq);
    model_step(1, rst, en, rq);
    #1;
    compare_all();
  endtask

  task automatic wait_phase(input string tag, input int p, input int el, input bit rq);
    int n = 0;
    while (!(m_phase[0] == p && m_elapsed[0] == el) && n < 400) begin
      cycle(0, 1, rq);
      n++;
    end
    check(tag, (n < 400), 1);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; ped_req = 1'b0;
    // Reset, then free-running with no requests.
    repeat (5) cycle(1, 0, 0);
    check("reset_out_a", obs_a, 8'h24);
    check("reset_out_b", obs_b, 8'h24);
    repeat (130) cycle(0, 1, 0);

    // Single request pulse in NS green cycle 5.
    wait_phase("wait_nsg5", PH_NS_G, 5, 0);
    cycle(0, 1, 1);
    check("ack_after_pulse", a_ack, 1);
    repeat (70) cycle(0, 1, 0);

    // Request held high for 200 cycles.
    repeat (200) cycle(0, 1, 1);
    repeat (40) cycle(0, 1, 0);

    // Disable for 10 cycles at NS yellow cycle 3, pulsing a request meanwhile.
    wait_phase("wait_nsy3", PH_NS_Y, 3, 0);
    for (int i = 0; i < 10; i++) cycle(0, 0, (i == 4));
    check("frozen_yellow", a_nsy, 1);
    repeat (40) cycle(0, 1, 0);

    // Reset during WALK with a request asserted.
    wait_phase("wait_walk", PH_WALK, 2, 1);
    cycle(1, 1, 1);
    check("reset_in_walk", obs_a, 8'h24);
    repeat (80) cycle(0, 1, 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++)
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0),
            ($urandom_range(0, 15) == 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
